w_k_scheduler: RTL and testbench

- Upstream neighbour of the SHA-256 compression round stage.
- Accepts one 512-bit padded message block and generates the 64 message-schedule words W0..W63, each paired with its round constant K0..K63, one round per clock.
- Drives the round stage's `enable`, `wk_vector_index`, `cur_w`, `cur_k` and `wk_index_complete` inputs directly.
- Uses a 16-word sliding window for the schedule recurrence and an internal 64-entry constant ROM.

---
 rtl/w_k_scheduler.sv | 128 ++++++++++++
 tb/tb_w_k_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/w_k_scheduler.sv
// w_k_scheduler: SHA-256 message-schedule W_t / K_t generator, one round per clock; optional stall port via `WK_STALL_EN
module w_k_scheduler #(
  parameter int WK_LENGTH = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [511:0]                 message_block,
`ifdef WK_STALL_EN
  input  logic                         stall,
`endif
  output logic                         enable,
  output logic [$clog2(WK_LENGTH)-1:0] wk_vector_index,
  output logic [31:0]                  cur_w,
  output logic [31:0]                  cur_k,
  output logic                         wk_index_complete,
  output logic                         busy
);
  localparam int IW = $clog2(WK_LENGTH);
  localparam logic [IW-1:0] LAST = IW'(WK_LENGTH - 1);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

  state_t        state, state_n;
  logic [IW-1:0] cnt, cnt_n;
  logic [31:0]   win [16];
  logic [31:0]   win_n [16];
  logic          en_n, cmp_n;
  logic [IW-1:0] idx_n;
  logic [31:0]   w_n, k_n;
  logic          hold;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

`ifdef WK_STALL_EN
  assign hold = stall && (state == RUN || state == FINAL);
`else
  assign hold = 1'b0;
`endif

  // Next state, window and output values; a stall freezes everything but drops enable
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    win_n   = win;
    en_n    = 1'b0;
    cmp_n   = 1'b0;
    idx_n   = '0;
    w_n     = '0;
    k_n     = '0;
    if (hold) begin
      cmp_n = wk_index_complete;
      idx_n = wk_vector_index;
      w_n   = cur_w;
      k_n   = cur_k;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state_n = RUN;
          cnt_n   = '0;
          for (int i = 0; i < 16; i++) win_n[i] = message_block[511 - 32*i -: 32];
          en_n    = 1'b1;
          w_n     = message_block[511:480];
          k_n     = K[0];
        end
        RUN: begin
          for (int i = 0; i < 15; i++) win_n[i] = win[i+1];
          win_n[15] = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
          en_n      = 1'b1;
          state_n   = (cnt == LAST) ? FINAL : RUN;
          cnt_n     = (cnt == LAST) ? cnt : cnt + 1'b1;
          cmp_n     = (cnt == LAST);
          idx_n     = (cnt == LAST) ? cnt : cnt + 1'b1;
          w_n       = (cnt == LAST) ? '0 : win[1];
          k_n       = (cnt == LAST) ? '0 : K[cnt + 1'b1];
        end
        FINAL: begin
          state_n = DONE;
          cnt_n   = '0;
          win_n   = '{default: '0};
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State, window and registered outputs; reset discards any partial block
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      win               <= '{default: '0};
      enable            <= 1'b0;
      wk_vector_index   <= '0;
      cur_w             <= '0;
      cur_k             <= '0;
      wk_index_complete <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      win               <= win_n;
      enable            <= en_n;
      wk_vector_index   <= idx_n;
      cur_w             <= w_n;
      cur_k             <= k_n;
      wk_index_complete <= cmp_n;
      busy              <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_w_k_scheduler.sv
// tb_w_k_scheduler: table vectors, random blocks against an array-based schedule model, start/reset/stall corners
module tb_w_k_scheduler;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [511:0] message_block = '0;
`ifdef WK_STALL_EN
  logic         stall = 1'b0;
`endif
  logic         enable;
  logic [5:0]   wk_vector_index;
  logic [31:0]  cur_w, cur_k;
  logic         wk_index_complete, busy;
  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;

  w_k_scheduler dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .message_block(message_block),
`ifdef WK_STALL_EN
    .stall(stall),
`endif
    .enable(enable),
    .wk_vector_index(wk_vector_index),
    .cur_w(cur_w),
    .cur_k(cur_k),
    .wk_index_complete(wk_index_complete),
    .busy(busy)
  );

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] tw [64];

  typedef struct {
    string        name;
    logic [511:0] blk;
    int           cyc;
    logic [72:0]  exp;
  } vec_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void expand(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) tw[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      tw[i] = (rotr(tw[i-2], 17) ^ rotr(tw[i-2], 19) ^ (tw[i-2] >> 10)) + tw[i-7]
            + (rotr(tw[i-15], 7) ^ rotr(tw[i-15], 18) ^ (tw[i-15] >> 3)) + tw[i-16];
  endfunction

  // expected {enable, index, w, k, complete, busy} c cycles after the start cycle
  function automatic logic [72:0] exp_at(input int c);
    if (c >= 1 && c <= 64) return {1'b1, 6'(c - 1), tw[c-1], KT[c-1], 1'b0, 1'b1};
    if (c == 65) return {1'b1, 6'd63, 32'd0, 32'd0, 1'b1, 1'b1};
    if (c == 66) return {1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 1'b1};
    return '0;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [72:0] exp);
    logic [72:0] got;
    got = {enable, wk_vector_index, cur_w, cur_k, wk_index_complete, busy};
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got en=%b idx=%0d w=%h k=%h cmp=%b busy=%b, expected en=%b idx=%0d w=%h k=%h cmp=%b busy=%b",
                  name, got[72], got[71:66], got[65:34], got[33:2], got[1], got[0],
                  exp[72], exp[71:66], exp[65:34], exp[33:2], exp[1], exp[0]);
  endtask

  // starts a block in the current (idle) cycle and checks all 67 following cycles; ends in an idle cycle
  task automatic run_full(input logic [511:0] blk, input bit pulses);
    expand(blk);
    message_block = blk;
    start = 1'b1;
    for (int c = 1; c <= 67; c++) begin
      tick();
      start = pulses && (c == 10 || c == 66);
      message_block = rand_blk();
      check(pulses ? "seq_pulsed" : "seq", exp_at(c));
    end
  endtask

  initial begin
    vec_t vt[$];
    logic [511:0] abc, zero, b;
    logic [72:0] e;
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0] = 32'h00000018;
    zero = '0;
    vt.push_back('{"abc_w0",    abc,  1, {1'b1, 6'd0,  32'h61626380, 32'h428a2f98, 1'b0, 1'b1}});
    vt.push_back('{"abc_w15",   abc, 16, {1'b1, 6'd15, 32'h00000018, 32'hc19bf174, 1'b0, 1'b1}});
    vt.push_back('{"abc_w16",   abc, 17, {1'b1, 6'd16, 32'h61626380, 32'he49b69c1, 1'b0, 1'b1}});
    vt.push_back('{"abc_w17",   abc, 18, {1'b1, 6'd17, 32'h000f0000, 32'hefbe4786, 1'b0, 1'b1}});
    vt.push_back('{"abc_w18",   abc, 19, {1'b1, 6'd18, 32'h7da86405, 32'h0fc19dc6, 1'b0, 1'b1}});
    vt.push_back('{"abc_w19",   abc, 20, {1'b1, 6'd19, 32'h600003c6, 32'h240ca1cc, 1'b0, 1'b1}});
    vt.push_back('{"abc_final", abc, 65, {1'b1, 6'd63, 32'd0, 32'd0, 1'b1, 1'b1}});
    vt.push_back('{"abc_done",  abc, 66, {1'b0, 6'd0,  32'd0, 32'd0, 1'b0, 1'b1}});
    vt.push_back('{"abc_idle",  abc, 67, 73'd0});
    vt.push_back('{"zero_k0",   zero, 1, {1'b1, 6'd0,  32'd0, 32'h428a2f98, 1'b0, 1'b1}});
    vt.push_back('{"zero_k63",  zero, 64, {1'b1, 6'd63, 32'd0, 32'hc67178f2, 1'b0, 1'b1}});

    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_after_reset", 73'd0);
    end

    foreach (vt[v]) begin
      message_block = vt[v].blk;
      start = 1'b1;
      for (int c = 1; c <= 67; c++) begin
        tick();
        start = 1'b0;
        if (c == vt[v].cyc) check(vt[v].name, vt[v].exp);
      end
    end

    run_full(abc, 1'b0);
    run_full(zero, 1'b0);
    run_full(rand_blk(), 1'b1);
    run_full(rand_blk(), 1'b0);
    run_full(rand_blk(), 1'b1);

    b = rand_blk();
    expand(b);
    message_block = b;
    start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      tick();
      start = 1'b0;
    end
    check("round30_before_reset", exp_at(31));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_run", 73'd0);
    run_full(rand_blk(), 1'b0);

`ifdef WK_STALL_EN
    b = rand_blk();
    expand(b);
    message_block = b;
    start = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      tick();
      start = 1'b0;
      stall = (c >= 21 && c <= 23);
      if (c <= 21) e = exp_at(c);
      else if (c <= 24) begin
        e = exp_at(21);
        e[72] = 1'b0;
      end else e = exp_at(c - 3);
      check("stall", e);
    end
    stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
